fft_peak_detect: RTL and testbench

- Consumes the FFT core's output word stream in parallel with the 8192-bit output packing buffer.
- For each frame, computes an approximate magnitude per bin from the 8-bit real/imag slices and tracks the strongest bin within a configurable search window.
- Counts bins above a programmable threshold.
- Presents a compact peak result (bin, magnitude, count) to the MCU-facing logic, so the MCU can get the answer without a full 8192-bit SPI readout.

---
 rtl/fft_peak_detect.sv | 97 +++++++++
 tb/tb_fft_peak_detect.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_detect.sv
// fft_peak_detect: per-frame strongest-bin search, magnitude and above-threshold count
// over the FFT output word stream, presented as a compact result for the MCU.
module fft_peak_detect #(
  parameter int N_BINS  = 512,
  parameter int MIN_BIN = 1,
  parameter int MAX_BIN = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fft_start,
  input  logic        fft_done,
  input  logic [31:0] fft_out32,
  input  logic [7:0]  threshold,
  output logic [8:0]  peak_bin,
  output logic [8:0]  peak_mag,
  output logic [9:0]  above_cnt,
  output logic        result_valid,
  output logic        result_pulse,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;
  state_t      state_q, state_d;
  logic [8:0]  bin_q, bin_d, s1_bin_q, s1_bin_d;
  logic [8:0]  peak_bin_q, peak_bin_d, peak_mag_q, peak_mag_d;
  logic [7:0]  s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d, s1_thr_q, s1_thr_d;
  logic [9:0]  cnt_q, cnt_d;
  logic        s1_valid_q, s1_valid_d, drain_q, drain_d;
  logic        valid_q, valid_d, pulse_q, pulse_d, busy_q, busy_d;
  logic        accept, last, in_win, hit;
  logic [7:0]  mx, mn;
  logic [8:0]  mag;
  always_comb begin
    accept     = state_q == ACCUM && fft_done && !fft_start;
    last       = accept && bin_q == 9'(N_BINS - 1);
    s1_valid_d = accept;
    s1_bin_d   = bin_q;
    s1_ar_d    = fft_out32[31] ? ~fft_out32[31:24] + 8'd1 : fft_out32[31:24];
    s1_ai_d    = fft_out32[15] ? ~fft_out32[15:8] + 8'd1 : fft_out32[15:8];
    s1_thr_d   = threshold;
    mx         = s1_ar_q > s1_ai_q ? s1_ar_q : s1_ai_q;
    mn         = s1_ar_q > s1_ai_q ? s1_ai_q : s1_ar_q;
    mag        = {1'b0, mx} + {2'b0, mn[7:1]};
    in_win     = s1_valid_q && s1_bin_q >= 9'(MIN_BIN) && s1_bin_q <= 9'(MAX_BIN);
    hit        = in_win && mag > peak_mag_q;
    bin_d      = fft_start ? 9'd0 : accept ? bin_q + 9'd1 : bin_q;
    peak_mag_d = fft_start ? 9'd0 : hit ? mag : peak_mag_q;
    peak_bin_d = fft_start ? 9'd0 : hit ? s1_bin_q : peak_bin_q;
    // count saturates rather than wrapping
    cnt_d      = fft_start ? 10'd0 :
                 in_win && mag > {1'b0, s1_thr_q} && cnt_q != 10'h3ff ? cnt_q + 10'd1 : cnt_q;
    drain_d    = state_q == DRAIN && !fft_start && !drain_q;
    state_d    = fft_start ? ACCUM : last ? DRAIN :
                 state_q == DRAIN && drain_q ? DONE : state_q;
    pulse_d    = state_d == DONE && state_q != DONE;
    valid_d    = state_d == DONE;
    busy_d     = state_d == ACCUM || state_d == DRAIN;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
      s1_ar_q    <= '0;
      s1_ai_q    <= '0;
      s1_thr_q   <= '0;
      peak_bin_q <= '0;
      peak_mag_q <= '0;
      cnt_q      <= '0;
      drain_q    <= 1'b0;
      valid_q    <= 1'b0;
      pulse_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      s1_valid_q <= s1_valid_d;
      s1_bin_q   <= s1_bin_d;
      s1_ar_q    <= s1_ar_d;
      s1_ai_q    <= s1_ai_d;
      s1_thr_q   <= s1_thr_d;
      peak_bin_q <= peak_bin_d;
      peak_mag_q <= peak_mag_d;
      cnt_q      <= cnt_d;
      drain_q    <= drain_d;
      valid_q    <= valid_d;
      pulse_q    <= pulse_d;
      busy_q     <= busy_d;
    end
  end
  assign peak_bin     = peak_bin_q;
  assign peak_mag     = peak_mag_q;
  assign above_cnt    = cnt_q;
  assign result_valid = valid_q;
  assign result_pulse = pulse_q;
  assign busy         = busy_q;
endmodule

// File: tb/tb_fft_peak_detect.sv
// tb_fft_peak_detect: directed and randomized frames checked against an arithmetic peak model.
module tb_fft_peak_detect;
  logic        clk = 1'b0;
  logic        reset, fft_start, fft_done;
  logic [31:0] fft_out32;
  logic [7:0]  threshold;
  logic [8:0]  peak_bin, peak_mag;
  logic [9:0]  above_cnt;
  logic        result_valid, result_pulse, busy;
  int          checks = 0, errors = 0, pcnt = 0, p0;
  logic [31:0] frame [512];
  int          m_bin, m_mag, m_cnt;

  fft_peak_detect dut (
    .clk(clk), .reset(reset), .fft_start(fft_start), .fft_done(fft_done),
    .fft_out32(fft_out32), .threshold(threshold), .peak_bin(peak_bin),
    .peak_mag(peak_mag), .above_cnt(above_cnt), .result_valid(result_valid),
    .result_pulse(result_pulse), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (result_pulse === 1'b1) pcnt++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_frame();
    for (int b = 0; b < 512; b++) frame[b] = {8'h00, 8'($urandom), 8'h00, 8'($urandom)};
  endtask

  task automatic set_bin(input int b, input int r, input int i);
    frame[b] = {8'(r), 8'($urandom), 8'(i), 8'($urandom)};
  endtask

  task automatic random_frame(input int amp);
    for (int b = 0; b < 512; b++) begin
      set_bin(b, int'($urandom_range(0, 2 * amp)) - amp, int'($urandom_range(0, 2 * amp)) - amp);
    end
  endtask

  function automatic int absval(input logic [7:0] v);
    logic signed [7:0] s;
    int x;
    s = v;
    x = s;
    return x < 0 ? -x : x;
  endfunction

  task automatic model();
    int ar, ai, mag;
    m_bin = 0; m_mag = 0; m_cnt = 0;
    for (int b = 1; b <= 255; b++) begin
      ar = absval(frame[b][31:24]);
      ai = absval(frame[b][15:8]);
      mag = (ar > ai ? ar : ai) + (ar > ai ? ai : ar) / 2;
      if (mag > m_mag) begin m_mag = mag; m_bin = b; end
      if (mag > int'(threshold) && m_cnt < 1023) m_cnt++;
    end
  endtask

  task automatic feed(input int first, input int last, input int gap);
    for (int b = first; b <= last; b++) begin
      fft_done = 1'b1;
      fft_out32 = frame[b];
      step();
      fft_done = 1'b0;
      if (b != last) repeat (gap) step();
    end
  endtask

  task automatic run_frame(input int gap, input bit collide);
    fft_start = 1'b1;
    fft_done = collide;
    fft_out32 = 32'h8000_8000;
    step();
    fft_start = 1'b0;
    fft_done = 1'b0;
    chk("busy_in_accum", busy, 1);
    feed(0, 511, gap);
  endtask

  task automatic finish_check(input string tag);
    model();
    chk({tag, "_pulse_e0"}, result_pulse, 0);
    chk({tag, "_valid_e0"}, result_valid, 0);
    step();
    chk({tag, "_pulse_e1"}, result_pulse, 0);
    chk({tag, "_busy_drain"}, busy, 1);
    step();
    chk({tag, "_pulse"}, result_pulse, 1);
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_bin"}, peak_bin, m_bin);
    chk({tag, "_mag"}, peak_mag, m_mag);
    chk({tag, "_cnt"}, above_cnt, m_cnt);
    step();
    chk({tag, "_pulse_off"}, result_pulse, 0);
    chk({tag, "_valid_hold"}, result_valid, 1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_bin"}, peak_bin, 0);
    chk({tag, "_mag"}, peak_mag, 0);
    chk({tag, "_cnt"}, above_cnt, 0);
    chk({tag, "_valid"}, result_valid, 0);
    chk({tag, "_pulse"}, result_pulse, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    reset = 1'b0; fft_start = 1'b0; fft_done = 1'b0; fft_out32 = '0; threshold = '0;
    repeat (3) step();
    chk_zero("reset");
    #2 reset = 1'b1;
    step();

    clear_frame();
    set_bin(50, 40, 0);
    threshold = 8'd10;
    fft_start = 1'b1;
    step();
    fft_start = 1'b0;
    feed(0, 99, 0);
    chk("pre_reset_mag", peak_mag, 40);
    chk("pre_reset_bin", peak_bin, 50);
    #2 reset = 1'b0;
    #1 chk_zero("async_reset");
    #3 reset = 1'b1;
    step();
    repeat (20) begin fft_done = 1'b1; fft_out32 = $urandom; step(); end
    fft_done = 1'b0;
    chk_zero("idle_ignore");

    clear_frame();
    set_bin(37, 40, -30);
    threshold = 8'd20;
    run_frame(0, 0);
    finish_check("tone");
    chk("tone_expect_mag", peak_mag, 55);

    clear_frame();
    set_bin(0, 100, 0); set_bin(300, 100, 0);
    set_bin(50, -64, 0); set_bin(80, -64, 0);
    threshold = 8'd63;
    run_frame(0, 0);
    finish_check("tie");
    chk("tie_expect_bin", peak_bin, 50);
    chk("tie_expect_cnt", above_cnt, 2);

    clear_frame();
    for (int k = 0; k < 30; k++) set_bin($urandom_range(1, 255), $urandom_range(1, 20), 0);
    set_bin(10, -128, -128);
    threshold = 8'd0;
    run_frame(0, 0);
    finish_check("extreme");
    chk("extreme_expect_mag", peak_mag, 192);

    p0 = pcnt;
    clear_frame();
    set_bin(20, 120, 0);
    threshold = 8'd30;
    fft_start = 1'b1;
    step();
    fft_start = 1'b0;
    feed(0, 199, 0);
    clear_frame();
    set_bin(90, 0, 70);
    run_frame(0, 0);
    finish_check("abort");
    chk("abort_expect_bin", peak_bin, 90);
    chk("abort_pulses", pcnt - p0, 1);

    clear_frame();
    set_bin(5, 50, 50);
    threshold = 8'd40;
    run_frame(0, 1);
    finish_check("collide");
    chk("collide_expect_bin", peak_bin, 5);

    p0 = pcnt;
    repeat (600) begin fft_done = 1'b1; fft_out32 = $urandom; step(); end
    fft_done = 1'b0;
    chk("done_ign_valid", result_valid, 1);
    chk("done_ign_bin", peak_bin, m_bin);
    chk("done_ign_mag", peak_mag, m_mag);
    chk("done_ign_cnt", above_cnt, m_cnt);
    chk("done_ign_pulses", pcnt - p0, 0);

    for (int t = 0; t < 4; t++) begin
      random_frame(t < 2 ? 60 : 128);
      threshold = 8'($urandom_range(0, 120));
      run_frame(0, 0);
      finish_check("random");
    end

    run_frame(2, 0);
    finish_check("gapped");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
